// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter and receiver.
// States, frame size and cycle-count derivations.
package ps2_host_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_SEND,
      S_ACK,
      S_WAITIDLE
   } state_t;

   localparam int FRAME_BITS = 11;

   function automatic int inhibit_cyc(input int khz);
      return khz / 10;
   endfunction

   function automatic int timeout_cyc(input int khz);
      return khz * 15;
   endfunction

   // bit 0 stands for the start bit so each fall shifts first
   function automatic logic [FRAME_BITS-1:0] frame_load(input logic [7:0] d);
      return {1'b1, ~^d, d, 1'b0};
   endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// PS/2 pin synchroniser with clock falling-edge detect.
// Shared by the host transmitter and the keyboard receiver.
module ps2_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic clk_in,
   input  logic dat_in,
   output logic clk_s,
   output logic dat_s,
   output logic clk_fall
);

   logic [1:0] c_sync;
   logic [1:0] d_sync;
   logic       c_prev;

   // idle bus level is high, so reset to 1 to avoid a spurious fall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_sync <= 2'b11;
         d_sync <= 2'b11;
         c_prev <= 1'b1;
      end else begin
         c_sync <= {c_sync[0], clk_in};
         d_sync <= {d_sync[0], dat_in};
         c_prev <= c_sync[1];
      end
   end

   assign clk_s    = c_sync[1];
   assign dat_s    = d_sync[1];
   assign clk_fall = c_prev & ~c_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter driving open-collector clock/data.
// Inhibit, request-to-send, bit shifting on device clock, ack check.
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int CLKFREQ_KHZ = 6000,
   parameter int INHIBIT_CYC = inhibit_cyc(CLKFREQ_KHZ),
   parameter int TIMEOUT_CYC = timeout_cyc(CLKFREQ_KHZ)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2clk_in,
   input  logic       ps2dat_in,
   output logic       ps2clk_oe,
   output logic       ps2dat_oe,
   input  logic [7:0] din,
   input  logic       send,
   output logic       busy,
   output logic       rx_inhibit,
   output logic       done,
   output logic       error
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYC - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT_CYC);

   state_t                  state, state_d;
   logic [TW-1:0]           tcnt, tcnt_d, tinc;
   logic [3:0]              bitcnt, bitcnt_d;
   logic [FRAME_BITS-1:0]   sh, sh_d;
   logic                    clk_oe_d, dat_oe_d;
   logic                    done_d, error_d;
   logic                    clk_s, dat_s, clk_fall;
   logic                    tout;

   ps2_line_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .clk_in   (ps2clk_in),
      .dat_in   (ps2dat_in),
      .clk_s    (clk_s),
      .dat_s    (dat_s),
      .clk_fall (clk_fall)
   );

   assign tinc = (tcnt == T_MAX) ? tcnt : tcnt + 1'b1;
   assign tout = (tcnt == TO_LAST);

   always_comb begin
      state_d  = state;
      tcnt_d   = tcnt;
      bitcnt_d = bitcnt;
      sh_d     = sh;
      clk_oe_d = ps2clk_oe;
      dat_oe_d = ps2dat_oe;
      done_d   = 1'b0;
      error_d  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (send) begin
               sh_d     = frame_load(din);
               bitcnt_d = '0;
               tcnt_d   = '0;
               clk_oe_d = 1'b1;
               dat_oe_d = 1'b0;
               state_d  = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (tcnt == INH_LAST) begin
               dat_oe_d = 1'b1;
               state_d  = S_RTS;
            end else begin
               tcnt_d = tinc;
            end
         end
         S_RTS: begin
            tcnt_d   = '0;
            clk_oe_d = 1'b0;
            state_d  = S_SEND;
         end
         S_SEND, S_ACK, S_WAITIDLE: begin
            tcnt_d = tinc;
            // timeout has priority over any bus event in the same cycle
            if (tout) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               error_d  = 1'b1;
               state_d  = S_IDLE;
            end else if (state == S_SEND) begin
               if (clk_fall) begin
                  sh_d     = {1'b1, sh[FRAME_BITS-1:1]};
                  dat_oe_d = ~sh[1];
                  bitcnt_d = bitcnt + 4'd1;
                  if (bitcnt == 4'd9) state_d = S_ACK;
               end
            end else if (state == S_ACK) begin
               if (clk_fall) begin
                  if (dat_s) begin
                     error_d = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_WAITIDLE;
                  end
               end
            end else if (clk_s && dat_s) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         tcnt      <= '0;
         bitcnt    <= '0;
         sh        <= '0;
         ps2clk_oe <= 1'b0;
         ps2dat_oe <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_d;
         tcnt      <= tcnt_d;
         bitcnt    <= bitcnt_d;
         sh        <= sh_d;
         ps2clk_oe <= clk_oe_d;
         ps2dat_oe <= dat_oe_d;
         busy      <= (state_d != S_IDLE);
         done      <= done_d;
         error     <= error_d;
      end
   end

   assign rx_inhibit = busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model on a wired-AND bus.
// Table frames, random frames, timeout, busy-send and reset cases.
module tb_ps2_host_tx;

   localparam int INH = 600;
   localparam int TO  = 9000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic [7:0] din = 8'h00;
   logic       send = 1'b0;
   logic       ps2clk_in, ps2dat_in;
   logic       ps2clk_oe, ps2dat_oe;
   logic       busy, rx_inhibit, done, error;

   assign ps2clk_in = dev_clk & ~ps2clk_oe;
   assign ps2dat_in = dev_dat & ~ps2dat_oe;

   ps2_host_tx #(
      .CLKFREQ_KHZ (6000),
      .INHIBIT_CYC (INH),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ps2clk_in  (ps2clk_in),
      .ps2dat_in  (ps2dat_in),
      .ps2clk_oe  (ps2clk_oe),
      .ps2dat_oe  (ps2dat_oe),
      .din        (din),
      .send       (send),
      .busy       (busy),
      .rx_inhibit (rx_inhibit),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, act, act, exp, exp);
      end
   endtask

   task automatic fail_to(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got no event within bound, expected event", name);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // monitor: invariants and event bookkeeping
   int   done_cnt = 0, err_cnt = 0, clkoe_tot = 0, inh_tot = 0;
   int   t_busy = 0, t_dat = 0, t_rel = 0, t_err = 0;
   logic busy_q = 1'b0, clk_q = 1'b0, dat_q = 1'b0;
   logic done_q = 1'b0, err_q = 1'b0;

   always @(negedge clk) begin
      chk("rx_inhibit_eq_busy", rx_inhibit, busy);
      chk("done_error_overlap", done & error, 0);
      if (done | error) chk("busy_at_pulse", busy, 0);
      if (done) chk("done_width", done_q, 0);
      if (error) chk("error_width", err_q, 0);
      if (busy & ~busy_q) t_busy <= cyc;
      if (ps2clk_oe & ps2dat_oe & ~dat_q) t_dat <= cyc;
      if (~ps2clk_oe & clk_q) t_rel <= cyc;
      if (error) t_err <= cyc;
      if (done) done_cnt <= done_cnt + 1;
      if (error) err_cnt <= err_cnt + 1;
      if (ps2clk_oe) clkoe_tot <= clkoe_tot + 1;
      if (ps2clk_oe & ~ps2dat_oe) inh_tot <= inh_tot + 1;
      busy_q <= busy;
      clk_q  <= ps2clk_oe;
      dat_q  <= ps2dat_oe;
      done_q <= done;
      err_q  <= error;
   end

   // reference: line levels seen by the device, start..stop
   function automatic logic [10:0] line_bits(input logic [7:0] b);
      logic [10:0] r;
      r[0] = 1'b0;
      for (int i = 0; i < 8; i++) r[i+1] = b[i];
      r[9]  = ($countones(b) % 2 == 0);
      r[10] = 1'b1;
      return r;
   endfunction

   task automatic do_send(input logic [7:0] b, output int scyc);
      @(posedge clk);
      #1;
      din  = b;
      send = 1'b1;
      scyc = cyc;
      tick(1);
      send = 1'b0;
      din  = 8'($urandom);
   endtask

   task automatic dev_frame(input int dly, input int half, input bit ack,
                            input int nfalls, output logic [10:0] bits);
      int n;
      bits = '1;
      n = 0;
      while (!ps2clk_oe && n < 50) begin tick(1); n++; end
      n = 0;
      while (ps2clk_oe && n < INH + 50) begin tick(1); n++; end
      if (ps2clk_oe) begin
         fail_to("clock_release");
         return;
      end
      tick(dly);
      bits[0] = ps2dat_in;
      for (int i = 1; i <= 10; i++) begin
         if (i > nfalls) break;
         dev_clk = 1'b0;
         tick(half);
         dev_clk = 1'b1;
         bits[i] = ps2dat_in;
         tick(half);
      end
      if (nfalls >= 11) begin
         if (ack) dev_dat = 1'b0;
         dev_clk = 1'b0;
         tick(half);
         dev_clk = 1'b1;
         tick(2);
         dev_dat = 1'b1;
      end
   endtask

   task automatic wait_idle(input int bound);
      int k = 0;
      while (busy && k < bound) begin tick(1); k++; end
      if (busy) fail_to("wait_idle");
   endtask

   task automatic frame_test(input logic [7:0] b, input int dly,
                             input int half, input bit ack,
                             output logic [10:0] bits);
      int d0, e0, c0, i0, scyc;
      d0 = done_cnt; e0 = err_cnt; c0 = clkoe_tot; i0 = inh_tot;
      do_send(b, scyc);
      dev_frame(dly, half, ack, 11, bits);
      wait_idle(100);
      tick(2);
      chk("t_busy", t_busy, scyc + 1);
      chk("t_rts", t_dat, scyc + 1 + INH);
      chk("t_release", t_rel, scyc + 2 + INH);
      chk("clk_oe_cycles", clkoe_tot - c0, INH + 1);
      chk("inhibit_cycles", inh_tot - i0, INH);
      chk("line_bits", bits, line_bits(b));
      chk("done_count", done_cnt - d0, ack ? 1 : 0);
      chk("error_count", err_cnt - e0, ack ? 0 : 1);
      chk("oe_after", {ps2clk_oe, ps2dat_oe, busy}, 0);
   endtask

   typedef struct {
      logic [7:0] b;
      int         half;
      bit         ack;
      logic       par;
   } vec_t;

   vec_t tbl[4];

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] bits;
      int          scyc, d0, e0;

      tbl[0] = '{b: 8'hED, half: 240, ack: 1'b1, par: 1'b1};
      tbl[1] = '{b: 8'hF4, half: 60,  ack: 1'b1, par: 1'b0};
      tbl[2] = '{b: 8'h00, half: 40,  ack: 1'b0, par: 1'b1};
      tbl[3] = '{b: 8'hFF, half: 30,  ack: 1'b1, par: 1'b1};

      tick(5);
      chk("reset_state", {ps2clk_oe, ps2dat_oe, busy, done, error}, 0);
      rst_n = 1'b1;
      tick(3);

      for (int i = 0; i < 6; i++) begin
         dev_clk = ~dev_clk;
         tick(10);
      end
      chk("idle_ignores_clk", {busy, ps2clk_oe, ps2dat_oe}, 0);

      for (int i = 0; i < 4; i++) begin
         frame_test(tbl[i].b, 300, tbl[i].half, tbl[i].ack, bits);
         chk("parity_bit", bits[9], tbl[i].par);
      end

      for (int r = 0; r < 6; r++) begin
         frame_test(8'($urandom), $urandom_range(20, 200),
                    $urandom_range(20, 60), $urandom_range(0, 4) != 0, bits);
      end

      e0 = err_cnt;
      do_send(8'hFF, scyc);
      wait_idle(INH + TO + 100);
      tick(2);
      chk("timeout_cycle", t_err, scyc + 2 + INH + TO);
      chk("timeout_errors", err_cnt - e0, 1);
      chk("timeout_release", {ps2clk_oe, ps2dat_oe}, 0);

      d0 = done_cnt;
      do_send(8'hED, scyc);
      fork
         dev_frame(100, 60, 1'b1, 11, bits);
         begin
            tick(INH + 400);
            din  = 8'h55;
            send = 1'b1;
            tick(1);
            send = 1'b0;
         end
      join
      wait_idle(100);
      tick(2);
      chk("busy_send_bits", bits, line_bits(8'hED));
      chk("busy_send_done", done_cnt - d0, 1);
      chk("busy_send_idle", busy, 0);

      d0 = done_cnt; e0 = err_cnt;
      do_send(8'hED, scyc);
      dev_frame(100, 60, 1'b1, 5, bits);
      chk("bit4_driven", {busy, ps2dat_oe}, 2'b11);
      rst_n = 1'b0;
      #1;
      chk("async_reset_release", {ps2clk_oe, ps2dat_oe, busy}, 0);
      tick(3);
      rst_n = 1'b1;
      tick(20);
      chk("reset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
      chk("reset_idle", {busy, ps2clk_oe, ps2dat_oe}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
